// File: rtl/frame_load_ctrl.sv
// -----------------------------------------------------------------------------
// frame_load_ctrl
//
// Write sequencer for a 4x4 frame register file. A burst of 8 words arriving
// on a valid/ready stream fills one half of a 16-word staging buffer; when the
// burst completes, a single-cycle write strobe pushes that half into the
// register file. Loaded halves are tracked so the stream can be stalled once
// the whole frame is present, until the consumer clears it.
//
// Staging layout: word i sits at frame_bus[i*DATA_W +: DATA_W], i = row*4+col.
// Half 0 ("small") covers cols 0-1, half 1 ("big") covers cols 2-3.
// Beat k of a burst into half h lands at index (k>>1)*4 + 2*h + (k&1), which is
// exactly the bit concatenation {k[2:1], h, k[0]}.
//
// Ports
//   clk, rst      clock, asynchronous active-high reset
//   in_valid      input word valid
//   in_ready      input word accepted when in_valid & in_ready
//   in_data       input word
//   in_half       target half, sampled on the first beat of a burst only
//   frame_clr     consumer has taken the frame; clears the loaded flags
//   frame_bus     16 staging words, flattened
//   wr_en         1-cycle write strobe to the register file
//   sb_sel        half select, meaningful while wr_en = 1
//   half_done     1-cycle pulse coincident with wr_en
//   loaded        bit h set once half h has been committed since the last clear
//   frame_full    both halves loaded
//   busy          burst in progress or committing
//   err_timeout   1-cycle pulse when a stalled burst is abandoned
//   state_dbg     current FSM state (0 IDLE, 1 FILL, 2 COMMIT)
//
// Handshake: a word transfers on a rising clock edge where in_valid and
// in_ready are both 1. in_ready does not depend on in_valid; in_valid may be
// raised or dropped at any time, and in_data/in_half are only looked at on a
// transfer edge.
// -----------------------------------------------------------------------------
module frame_load_ctrl #(
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [DATA_W-1:0]    in_data,
    input  logic                 in_half,
    input  logic                 frame_clr,
    output logic [16*DATA_W-1:0] frame_bus,
    output logic                 wr_en,
    output logic                 sb_sel,
    output logic                 half_done,
    output logic [1:0]           loaded,
    output logic                 frame_full,
    output logic                 busy,
    output logic                 err_timeout,
    output logic [1:0]           state_dbg
);

    // Idle counter only needs to reach TIMEOUT; keep at least one bit so the
    // declaration stays legal when the watchdog is disabled.
    localparam int IDLE_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [IDLE_W-1:0] TO_VAL = IDLE_W'(TIMEOUT);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_FILL   = 2'd1,
        S_COMMIT = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [2:0]          beat_q, beat_d;
    logic                half_q, half_d;
    logic [IDLE_W-1:0]   idle_q, idle_d;
    logic [IDLE_W-1:0]   idle_next;
    logic [1:0]          loaded_q, loaded_d;
    logic                err_q, err_d;
    logic [DATA_W-1:0]   stage_q [16];

    logic                accept;
    logic                beat_half;
    logic [3:0]          wr_idx;

    // ---------------------------------------------------------------------
    // Handshake and write addressing
    // ---------------------------------------------------------------------
    // in_ready is forced low while reset is held so every output reads 0
    // during reset, not only the registered ones.
    assign in_ready = ~rst & (((state_q == S_IDLE) & ~frame_full) |
                              (state_q == S_FILL));
    assign accept   = in_valid & in_ready;

    // On the first beat the half comes straight from the input; afterwards the
    // latched half is used so in_half changes mid-burst have no effect.
    assign beat_half = (state_q == S_IDLE) ? in_half : half_q;

    // beat_q is 0 whenever the FSM is idle, so the first beat maps to k = 0.
    assign wr_idx    = {beat_q[2:1], beat_half, beat_q[0]};

    assign idle_next = idle_q + 1'b1;

    // ---------------------------------------------------------------------
    // Next-state logic
    // ---------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        beat_d   = beat_q;
        half_d   = half_q;
        idle_d   = idle_q;
        err_d    = 1'b0;
        // Clear applies in any state; a commit in the same cycle then sets
        // only its own half on top of the cleared value.
        loaded_d = frame_clr ? 2'b00 : loaded_q;

        case (state_q)
            S_IDLE: begin
                idle_d = '0;
                beat_d = 3'd0;
                if (accept) begin
                    half_d  = in_half;
                    beat_d  = 3'd1;
                    state_d = S_FILL;
                end
            end

            S_FILL: begin
                if (accept) begin
                    idle_d = '0;
                    if (beat_q == 3'd7) begin
                        beat_d  = 3'd0;
                        state_d = S_COMMIT;
                    end else begin
                        beat_d = beat_q + 3'd1;
                    end
                end else if (TIMEOUT > 0) begin
                    // Abort on the edge where the idle count reaches TIMEOUT.
                    // Staging keeps its partial contents; they are simply
                    // never committed.
                    if (idle_next == TO_VAL) begin
                        idle_d  = '0;
                        beat_d  = 3'd0;
                        err_d   = 1'b1;
                        state_d = S_IDLE;
                    end else if (idle_q != TO_VAL) begin
                        idle_d = idle_next;
                    end
                end
            end

            S_COMMIT: begin
                loaded_d[half_q] = 1'b1;
                state_d          = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
                beat_d  = 3'd0;
                idle_d  = '0;
            end
        endcase
    end

    // ---------------------------------------------------------------------
    // State registers
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            beat_q   <= 3'd0;
            half_q   <= 1'b0;
            idle_q   <= '0;
            loaded_q <= 2'b00;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            beat_q   <= beat_d;
            half_q   <= half_d;
            idle_q   <= idle_d;
            loaded_q <= loaded_d;
            err_q    <= err_d;
        end
    end

    // Staging buffer: one word written per accepted beat, nothing else moves
    // it, so it is naturally stable through COMMIT.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 16; i++) begin
                stage_q[i] <= '0;
            end
        end else if (accept) begin
            stage_q[wr_idx] <= in_data;
        end
    end

    // ---------------------------------------------------------------------
    // Outputs
    // ---------------------------------------------------------------------
    for (genvar gi = 0; gi < 16; gi++) begin : g_bus
        assign frame_bus[gi*DATA_W +: DATA_W] = stage_q[gi];
    end

    assign wr_en       = (state_q == S_COMMIT);
    assign sb_sel      = wr_en & half_q;
    assign half_done   = wr_en;
    assign loaded      = loaded_q;
    assign frame_full  = &loaded_q;
    assign busy        = (state_q != S_IDLE);
    assign err_timeout = err_q;
    assign state_dbg   = state_q;

endmodule

// File: tb/tb_frame_load_ctrl.sv
// -----------------------------------------------------------------------------
// tb_frame_load_ctrl
//
// Bench for frame_load_ctrl with a short watchdog (TIMEOUT = 4). Bursts are
// described by a table of records; each committed half is predicted from a
// bench-side staging model and queued, then matched against the write strobe.
// -----------------------------------------------------------------------------
module tb_frame_load_ctrl;

    localparam int DATA_W  = 32;
    localparam int TIMEOUT = 4;
    localparam int W       = 16 * DATA_W + 1;

    // ---------------------------------------------------------------------
    // Clock / reset / DUT
    // ---------------------------------------------------------------------
    logic                 clk = 1'b0;
    logic                 rst;
    logic                 in_valid;
    logic                 in_ready;
    logic [DATA_W-1:0]    in_data;
    logic                 in_half;
    logic                 frame_clr;
    logic [16*DATA_W-1:0] frame_bus;
    logic                 wr_en;
    logic                 sb_sel;
    logic                 half_done;
    logic [1:0]           loaded;
    logic                 frame_full;
    logic                 busy;
    logic                 err_timeout;
    logic [1:0]           state_dbg;

    always #5 clk = ~clk;

    frame_load_ctrl #(.DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .in_half     (in_half),
        .frame_clr   (frame_clr),
        .frame_bus   (frame_bus),
        .wr_en       (wr_en),
        .sb_sel      (sb_sel),
        .half_done   (half_done),
        .loaded      (loaded),
        .frame_full  (frame_full),
        .busy        (busy),
        .err_timeout (err_timeout),
        .state_dbg   (state_dbg)
    );

    // ---------------------------------------------------------------------
    // Scoreboard state and bench-side model
    // ---------------------------------------------------------------------
    int n_chk  = 0;
    int n_fail = 0;
    int err_seen = 0;

    logic [W-1:0]      exp_q [$];
    logic [DATA_W-1:0] exp_stage [16];
    int                model_k;
    logic              model_h;

    typedef struct {
        logic              half;
        logic [DATA_W-1:0] base;
        logic              bubbles;
        logic              toggle;
        logic              clr_in_commit;
        logic              clr_after;
        logic [1:0]        exp_loaded;
    } vec_t;

    vec_t vecs [7];

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [W-1:0] snap();
        logic [W-1:0] f;
        f = '0;
        for (int i = 0; i < 16; i++) f[i*DATA_W +: DATA_W] = exp_stage[i];
        f[W-1] = model_h;
        return f;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 16; i++) exp_stage[i] = '0;
        model_k = 0;
        model_h = 1'b0;
        exp_q.delete();
    endtask

    // Commit monitor: every write strobe must match the oldest predicted one.
    always @(negedge clk) begin : mon
        logic [W-1:0] e;
        if (!rst) begin
            if (err_timeout) err_seen++;
            if (wr_en || half_done) begin
                chk("wr_en", wr_en, 1);
                chk("half_done", half_done, 1);
                if (exp_q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_commit: got sb_sel=%0d expected no write", sb_sel);
                end else begin
                    e = exp_q.pop_front();
                    chk("commit_frame", {sb_sel, frame_bus}, e);
                end
            end
        end
    end

    // ---------------------------------------------------------------------
    // Driver tasks (called at a negedge, return at a negedge)
    // ---------------------------------------------------------------------
    task automatic send_beat(input logic [DATA_W-1:0] d, input logic h);
        int n;
        n        = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_half  = h;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            n_chk++;
            n_fail++;
            $display("FAIL handshake_wait: got in_ready=0 expected 1 within 50 cycles");
            in_valid = 1'b0;
            return;
        end
        if (model_k == 0) model_h = h;
        exp_stage[(model_k / 2) * 4 + 2 * int'(model_h) + (model_k % 2)] = d;
        model_k++;
        if (model_k == 8) begin
            exp_q.push_back(snap());
            model_k = 0;
        end
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic run_burst(input logic h, input logic [DATA_W-1:0] base,
                             input logic bubbles, input logic toggle);
        logic hh;
        for (int k = 0; k < 8; k++) begin
            hh = (toggle && k >= 1) ? ~h : h;
            send_beat(base + DATA_W'(k), hh);
            if (bubbles && k < 7) repeat ($urandom_range(0, 2)) @(negedge clk);
        end
    endtask

    // ---------------------------------------------------------------------
    // Global time limit
    // ---------------------------------------------------------------------
    initial begin
        #500000;
        n_fail++;
        $display("FAIL global_time_limit: got no finish expected finish before 500000");
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    // ---------------------------------------------------------------------
    // Main sequence
    // ---------------------------------------------------------------------
    initial begin
        int err_before;

        vecs[0] = '{1'b0, 32'h100, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01};
        vecs[1] = '{1'b1, 32'h200, 1'b0, 1'b0, 1'b0, 1'b1, 2'b11};
        vecs[2] = '{1'b0, 32'h300, 1'b1, 1'b1, 1'b0, 1'b0, 2'b01};
        vecs[3] = '{1'b0, 32'h400, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01};
        vecs[4] = '{1'b1, 32'h500, 1'b1, 1'b0, 1'b0, 1'b1, 2'b11};
        vecs[5] = '{1'b0, 32'h700, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01};
        vecs[6] = '{1'b1, 32'h800, 1'b0, 1'b0, 1'b1, 1'b0, 2'b10};

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_half   = 1'b0;
        frame_clr = 1'b0;
        model_clear();

        // Reset values
        repeat (2) @(negedge clk);
        chk("rst_wr_en", wr_en, 0);
        chk("rst_sb_sel", sb_sel, 0);
        chk("rst_half_done", half_done, 0);
        chk("rst_loaded", loaded, 0);
        chk("rst_frame_full", frame_full, 0);
        chk("rst_busy", busy, 0);
        chk("rst_err_timeout", err_timeout, 0);
        chk("rst_frame_bus", frame_bus, 0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_state", state_dbg, 0);
        rst = 1'b0;
        #1;
        chk("rel_in_ready", in_ready, 1);
        @(negedge clk);

        // Asynchronous reset in the middle of a burst discards it
        for (int k = 0; k < 3; k++) send_beat(32'h900 + DATA_W'(k), 1'b1);
        chk("midburst_busy", busy, 1);
        #2 rst = 1'b1;
        #1;
        chk("async_busy", busy, 0);
        chk("async_frame_bus", frame_bus, 0);
        chk("async_in_ready", in_ready, 0);
        chk("async_state", state_dbg, 0);
        model_clear();
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("async_rel_in_ready", in_ready, 1);
        @(negedge clk);

        // Table-driven bursts
        for (int v = 0; v < 7; v++) begin
            run_burst(vecs[v].half, vecs[v].base, vecs[v].bubbles, vecs[v].toggle);
            // Now in the COMMIT cycle
            if (vecs[v].clr_in_commit) frame_clr = 1'b1;
            @(negedge clk);
            frame_clr = 1'b0;
            chk("commit_seen", exp_q.size(), 0);
            chk("loaded", loaded, vecs[v].exp_loaded);
            chk("frame_full", frame_full, vecs[v].exp_loaded == 2'b11);
            chk("busy_after", busy, 0);
            chk("in_ready_after", in_ready, vecs[v].exp_loaded != 2'b11);
            if (vecs[v].exp_loaded == 2'b11) begin
                // Stream must stay stalled while the frame is full
                in_valid = 1'b1;
                in_data  = 32'hdead;
                in_half  = 1'b0;
                repeat (3) begin
                    @(negedge clk);
                    chk("full_stall_ready", in_ready, 0);
                    chk("full_stall_busy", busy, 0);
                end
                in_valid = 1'b0;
            end
            if (vecs[v].clr_after) begin
                frame_clr = 1'b1;
                @(negedge clk);
                frame_clr = 1'b0;
                chk("clr_loaded", loaded, 0);
                chk("clr_frame_full", frame_full, 0);
                chk("clr_in_ready", in_ready, 1);
            end
        end

        // Watchdog: 3 beats then silence, loaded stays at 10
        err_before = err_seen;
        for (int k = 0; k < 3; k++) send_beat(32'h600 + DATA_W'(k), 1'b1);
        repeat (8) @(negedge clk);
        chk("timeout_pulses", err_seen - err_before, 1);
        chk("timeout_loaded", loaded, 2'b10);
        chk("timeout_busy", busy, 0);
        chk("timeout_no_commit", exp_q.size(), 0);
        model_k = 0;

        // Next burst restarts at beat 0; partial words of the aborted burst
        // remain in the other half of the staging buffer.
        run_burst(1'b0, 32'hA00, 1'b0, 1'b0);
        @(negedge clk);
        chk("final_commit_seen", exp_q.size(), 0);
        chk("final_loaded", loaded, 2'b11);
        chk("final_frame_full", frame_full, 1);
        chk("total_err_pulses", err_seen, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
